// File: rtl/core_completion_monitor.sv
// core_completion_monitor
//   Run controller and finish detector for a multi-core top level. Each core
//   gets an independent IDLE -> RUN -> DRAIN -> DONE tracker: RUN counts edges
//   since start until the core's PC hits its halt address, DRAIN waits for the
//   pipeline to empty, DONE holds the result until the next start or reset.
//
//   Optional watchdog: define CORE_MONITOR_TIMEOUT_EN to stop a core that has
//   not halted after TIMEOUT_CYCLES run edges. Without it core_timeout is 0.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   start         in   1-cycle pulse, (re)starts a run on every core
//   PC            in   per-core PC, core i at [i*ADDRESS_BITS +: ADDRESS_BITS]
//   halt_address  in   per-core finish PC, same packing
//   core_done     out  core i halted and drain elapsed (or timed out)
//   core_timeout  out  core i stopped by the watchdog
//   run_cycles    out  latched run length, core i at [i*CYCLE_BITS +: CYCLE_BITS]
//   all_done      out  every core done
//   busy          out  some core in RUN or DRAIN

module core_completion_monitor_core #(
  parameter int ADDRESS_BITS   = 32,
  parameter int CYCLE_BITS     = 32,
  parameter int DRAIN_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [ADDRESS_BITS-1:0] i_pc,
  input  logic [ADDRESS_BITS-1:0] i_halt,
  output logic                    o_done,
  output logic                    o_tmo,
  output logic [CYCLE_BITS-1:0]   o_cycles,
  output logic                    o_active
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
`ifdef CORE_MONITOR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  // Watchdog compare is constant-false, so the timeout path folds away.
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic [CYCLE_BITS-1:0] r_cnt;
  logic [DW-1:0]         r_dcnt;
  logic                  r_done;
  logic                  r_tmo;
  logic [CYCLE_BITS-1:0] r_cycles;

  logic                  w_match;
  logic [CYCLE_BITS-1:0] w_cnt_sat;
  logic [CYCLE_BITS:0]   w_cnt_ext;
  logic                  w_tmo_hit;

  assign w_match   = (i_pc == i_halt);
  // Saturating increment: a core that never halts parks at all-ones, and a
  // late halt then reports all-ones rather than a wrapped small count.
  assign w_cnt_sat = (&r_cnt) ? r_cnt : r_cnt + CYCLE_BITS'(1);
  // One extra bit so the watchdog compare cannot alias through a wrap.
  assign w_cnt_ext = {1'b0, r_cnt} + (CYCLE_BITS+1)'(1);
  assign w_tmo_hit = TMO_EN && (w_cnt_ext == (CYCLE_BITS+1)'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dcnt   <= '0;
      r_done   <= 1'b0;
      r_tmo    <= 1'b0;
      r_cycles <= '0;
    end else if (i_start) begin
      // start overrides every state: restart from a clean slate
      r_state  <= S_RUN;
      r_cnt    <= '0;
      r_dcnt   <= '0;
      r_done   <= 1'b0;
      r_tmo    <= 1'b0;
      r_cycles <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          // halt match beats the watchdog on the same edge
          if (w_match) begin
            r_cycles <= w_cnt_sat;
            r_dcnt   <= '0;
            r_state  <= S_DRAIN;
          end else if (w_tmo_hit) begin
            r_cycles <= CYCLE_BITS'(TIMEOUT_CYCLES);
            r_done   <= 1'b1;
            r_tmo    <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= w_cnt_sat;
          end
        end
        S_DRAIN: begin
          // PC is a committed self-loop here, so it is not watched
          if (r_dcnt == DW'(DRAIN_CYCLES - 1)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_done   = r_done;
  assign o_tmo    = r_tmo;
  assign o_cycles = r_cycles;
  assign o_active = (r_state == S_RUN) || (r_state == S_DRAIN);
endmodule

module core_completion_monitor #(
  parameter int NUM_CORES      = 2,
  parameter int ADDRESS_BITS   = 32,
  parameter int CYCLE_BITS     = 32,
  parameter int DRAIN_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_CORES*ADDRESS_BITS-1:0] PC,
  input  logic [NUM_CORES*ADDRESS_BITS-1:0] halt_address,
  output logic [NUM_CORES-1:0]              core_done,
  output logic [NUM_CORES-1:0]              core_timeout,
  output logic [NUM_CORES*CYCLE_BITS-1:0]   run_cycles,
  output logic                              all_done,
  output logic                              busy
);
  logic [NUM_CORES-1:0] w_active;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    core_completion_monitor_core #(
      .ADDRESS_BITS  (ADDRESS_BITS),
      .CYCLE_BITS    (CYCLE_BITS),
      .DRAIN_CYCLES  (DRAIN_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_core (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_start (start),
      .i_pc    (PC[gi*ADDRESS_BITS +: ADDRESS_BITS]),
      .i_halt  (halt_address[gi*ADDRESS_BITS +: ADDRESS_BITS]),
      .o_done  (core_done[gi]),
      .o_tmo   (core_timeout[gi]),
      .o_cycles(run_cycles[gi*CYCLE_BITS +: CYCLE_BITS]),
      .o_active(w_active[gi])
    );
  end

  assign all_done = &core_done;
  assign busy     = |w_active;
endmodule
